// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake,
// optional two-entry skid buffer and flush with optional bubble.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop held entries (or replace with one NOP_VALUE)
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data = head entry
//   occupancy       entries held (0..2)
module pipe_stage_reg #(
    parameter int unsigned      WIDTH        = 32,
    parameter bit               SKID         = 1'b1,
    parameter bit               NOP_ON_FLUSH = 1'b1,
    parameter logic [WIDTH-1:0] NOP_VALUE    = WIDTH'(32'h00000013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic             push, pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;
    assign occupancy = state_q;

    // With a skid entry, ready comes from a flop and never sees
    // out_ready; without it, ready passes straight through.
    assign in_ready = SKID ? rdy_q : (!out_valid || out_ready);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // A push landing in this cycle is swallowed here.
            if (NOP_ON_FLUSH) begin
                state_d = ONE;
                head_d  = NOP_VALUE;
            end else begin
                state_d = EMPTY;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        head_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_data;
                    end else if (push && SKID) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        rdy_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks for pipe_stage_reg.
// Instances cover both SKID modes, both flush modes, WIDTH 1/32/128.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // u0: WIDTH 32, SKID 1, NOP on flush
    logic        fl0, iv0, ir0, ov0, or0;
    logic [31:0] id0, od0;
    logic [1:0]  oc0;
    pipe_stage_reg #(.WIDTH(32), .SKID(1), .NOP_ON_FLUSH(1)) u0 (
        .clk(clk), .rst(rst), .flush(fl0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(oc0)
    );

    // u1: WIDTH 32, SKID 0, NOP on flush
    logic        fl1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [1:0]  oc1;
    pipe_stage_reg #(.WIDTH(32), .SKID(0), .NOP_ON_FLUSH(1)) u1 (
        .clk(clk), .rst(rst), .flush(fl1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(oc1)
    );

    // u2: WIDTH 32, SKID 1, flush empties
    logic        fl2, iv2, ir2, ov2, or2;
    logic [31:0] id2, od2;
    logic [1:0]  oc2;
    pipe_stage_reg #(.WIDTH(32), .SKID(1), .NOP_ON_FLUSH(0)) u2 (
        .clk(clk), .rst(rst), .flush(fl2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .occupancy(oc2)
    );

    // Soak instances:
    //   0: W1   SKID0 NOP1   1: W1   SKID1 NOP0
    //   2: W128 SKID0 NOP0   3: W128 SKID1 NOP1
    logic [3:0]        sfl, siv, sir, sov, sor;
    logic [3:0][127:0] sid, sobs;
    logic [3:0][1:0]   soc;
    logic [0:0]        so0, so1;
    logic [127:0]      so2, so3;

    assign sobs[0] = {127'b0, so0};
    assign sobs[1] = {127'b0, so1};
    assign sobs[2] = so2;
    assign sobs[3] = so3;

    pipe_stage_reg #(.WIDTH(1), .SKID(0), .NOP_ON_FLUSH(1)) s0 (
        .clk(clk), .rst(rst), .flush(sfl[0]),
        .in_valid(siv[0]), .in_ready(sir[0]), .in_data(sid[0][0:0]),
        .out_valid(sov[0]), .out_ready(sor[0]), .out_data(so0),
        .occupancy(soc[0])
    );
    pipe_stage_reg #(.WIDTH(1), .SKID(1), .NOP_ON_FLUSH(0)) s1 (
        .clk(clk), .rst(rst), .flush(sfl[1]),
        .in_valid(siv[1]), .in_ready(sir[1]), .in_data(sid[1][0:0]),
        .out_valid(sov[1]), .out_ready(sor[1]), .out_data(so1),
        .occupancy(soc[1])
    );
    pipe_stage_reg #(.WIDTH(128), .SKID(0), .NOP_ON_FLUSH(0)) s2 (
        .clk(clk), .rst(rst), .flush(sfl[2]),
        .in_valid(siv[2]), .in_ready(sir[2]), .in_data(sid[2]),
        .out_valid(sov[2]), .out_ready(sor[2]), .out_data(so2),
        .occupancy(soc[2])
    );
    pipe_stage_reg #(.WIDTH(128), .SKID(1), .NOP_ON_FLUSH(1)) s3 (
        .clk(clk), .rst(rst), .flush(sfl[3]),
        .in_valid(siv[3]), .in_ready(sir[3]), .in_data(sid[3]),
        .out_valid(sov[3]), .out_ready(sor[3]), .out_data(so3),
        .occupancy(soc[3])
    );

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (oc0 !== 2'd0 || ov0 !== 1'b0 || od0 !== 32'h0 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_u0: oc=%0d ov=%0b od=%h ir=%0b want 0 0 0 1",
                     oc0, ov0, od0, ir0);
        end
        checks++;
        if (oc1 !== 2'd0 || ov1 !== 1'b0 || od1 !== 32'h0 || ir1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_u1: oc=%0d ov=%0b od=%h ir=%0b want 0 0 0 1",
                     oc1, ov1, od1, ir1);
        end
        checks++;
        if (oc2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_u2: oc=%0d ov=%0b ir=%0b want 0 0 1",
                     oc2, ov2, ir2);
        end
    endtask

    task automatic test_stream();
        or0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            iv0 = 1'b1;
            id0 = 32'(i);
            #1;
            checks++;
            if (ir0 !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready%0d: got %0b want 1", i, ir0);
            end
            if (i > 1) begin
                checks++;
                if (ov0 !== 1'b1 || od0 !== 32'(i - 1) || oc0 !== 2'd1) begin
                    failures++;
                    $display("FAIL stream_out%0d: ov=%0b od=%h oc=%0d want 1 %h 1",
                             i, ov0, od0, oc0, 32'(i - 1));
                end
            end
        end
        @(negedge clk);
        iv0 = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b1 || od0 !== 32'h8 || oc0 !== 2'd1) begin
            failures++;
            $display("FAIL stream_last: ov=%0b od=%h oc=%0d want 1 8 1",
                     ov0, od0, oc0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b0 || oc0 !== 2'd0) begin
            failures++;
            $display("FAIL stream_drain: ov=%0b oc=%0d want 0 0", ov0, oc0);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        or0 = 1'b0;
        iv0 = 1'b1;
        id0 = 32'hA;
        #1;
        checks++;
        if (ir0 !== 1'b1 || oc0 !== 2'd0) begin
            failures++;
            $display("FAIL bp_a: ir=%0b oc=%0d want 1 0", ir0, oc0);
        end
        @(negedge clk);
        id0 = 32'hB;
        #1;
        checks++;
        if (ir0 !== 1'b1 || oc0 !== 2'd1 || od0 !== 32'hA) begin
            failures++;
            $display("FAIL bp_b: ir=%0b oc=%0d od=%h want 1 1 a", ir0, oc0, od0);
        end
        @(negedge clk);
        id0 = 32'hC;
        #1;
        checks++;
        if (ir0 !== 1'b0 || oc0 !== 2'd2 || od0 !== 32'hA) begin
            failures++;
            $display("FAIL bp_full: ir=%0b oc=%0d od=%h want 0 2 a", ir0, oc0, od0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ir0 !== 1'b0 || oc0 !== 2'd2 || od0 !== 32'hA) begin
            failures++;
            $display("FAIL bp_stall: ir=%0b oc=%0d od=%h want 0 2 a", ir0, oc0, od0);
        end
        or0 = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ir0 !== 1'b1 || oc0 !== 2'd1 || od0 !== 32'hB) begin
            failures++;
            $display("FAIL bp_pop_a: ir=%0b oc=%0d od=%h want 1 1 b", ir0, oc0, od0);
        end
        @(negedge clk);
        iv0 = 1'b0;
        #1;
        checks++;
        if (oc0 !== 2'd1 || od0 !== 32'hC) begin
            failures++;
            $display("FAIL bp_pop_b: oc=%0d od=%h want 1 c", oc0, od0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (oc0 !== 2'd0 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: oc=%0d ov=%0b want 0 0", oc0, ov0);
        end
    endtask

    task automatic test_comb_ready();
        @(negedge clk);
        or1 = 1'b0;
        iv1 = 1'b1;
        id1 = 32'h55;
        @(negedge clk);
        iv1 = 1'b0;
        #1;
        checks++;
        if (oc1 !== 2'd1 || ir1 !== 1'b0 || od1 !== 32'h55) begin
            failures++;
            $display("FAIL comb_full: oc=%0d ir=%0b od=%h want 1 0 55", oc1, ir1, od1);
        end
        or1 = 1'b1;
        #1;
        checks++;
        if (ir1 !== 1'b1) begin
            failures++;
            $display("FAIL comb_rise: ir=%0b want 1", ir1);
        end
        or1 = 1'b0;
        #1;
        checks++;
        if (ir1 !== 1'b0) begin
            failures++;
            $display("FAIL comb_fall: ir=%0b want 0", ir1);
        end
        or1 = 1'b1;
        iv1 = 1'b1;
        id1 = 32'h66;
        @(negedge clk);
        or1 = 1'b0;
        id1 = 32'h77;
        #1;
        checks++;
        if (oc1 !== 2'd1 || od1 !== 32'h66 || ir1 !== 1'b0) begin
            failures++;
            $display("FAIL comb_swap: oc=%0d od=%h ir=%0b want 1 66 0", oc1, od1, ir1);
        end
        @(negedge clk);
        iv1 = 1'b0;
        #1;
        checks++;
        if (oc1 !== 2'd1 || od1 !== 32'h66) begin
            failures++;
            $display("FAIL comb_hold: oc=%0d od=%h want 1 66", oc1, od1);
        end
        or1 = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (oc1 !== 2'd0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL comb_drain: oc=%0d ov=%0b want 0 0", oc1, ov1);
        end
    endtask

    task automatic test_flush_nop();
        @(negedge clk);
        or0 = 1'b0;
        iv0 = 1'b1;
        id0 = 32'hA;
        @(negedge clk);
        id0 = 32'hB;
        @(negedge clk);
        id0 = 32'hC;
        fl0 = 1'b1;
        #1;
        checks++;
        if (oc0 !== 2'd2) begin
            failures++;
            $display("FAIL fnop_pre: oc=%0d want 2", oc0);
        end
        @(negedge clk);
        fl0 = 1'b0;
        iv0 = 1'b0;
        #1;
        checks++;
        if (oc0 !== 2'd1 || ov0 !== 1'b1 || od0 !== 32'h13 || ir0 !== 1'b1) begin
            failures++;
            $display("FAIL fnop_full: oc=%0d ov=%0b od=%h ir=%0b want 1 1 13 1",
                     oc0, ov0, od0, ir0);
        end
        // flush while a push really completes
        fl0 = 1'b1;
        iv0 = 1'b1;
        id0 = 32'hC;
        @(negedge clk);
        fl0 = 1'b0;
        iv0 = 1'b0;
        #1;
        checks++;
        if (oc0 !== 2'd1 || od0 !== 32'h13) begin
            failures++;
            $display("FAIL fnop_push: oc=%0d od=%h want 1 13", oc0, od0);
        end
        or0 = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (oc0 !== 2'd0 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL fnop_drain: oc=%0d ov=%0b want 0 0", oc0, ov0);
        end
    endtask

    task automatic test_flush_empty();
        @(negedge clk);
        or2 = 1'b0;
        iv2 = 1'b1;
        id2 = 32'hA;
        @(negedge clk);
        id2 = 32'hB;
        @(negedge clk);
        id2 = 32'hC;
        fl2 = 1'b1;
        @(negedge clk);
        fl2 = 1'b0;
        iv2 = 1'b0;
        #1;
        checks++;
        if (oc2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
            failures++;
            $display("FAIL fempty: oc=%0d ov=%0b ir=%0b want 0 0 1", oc2, ov2, ir2);
        end
    endtask

    task automatic test_reset_mid();
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            or0 = 1'b0;
            iv0 = 1'b1;
            id0 = 32'hA;
            @(negedge clk);
            id0 = 32'hB;
            @(negedge clk);
            iv0 = 1'b0;
            #1;
            checks++;
            if (oc0 !== 2'd2) begin
                failures++;
                $display("FAIL rmid_pre%0d: oc=%0d want 2", m, oc0);
            end
            rst = 1'b1;
            fl0 = (m == 1);
            @(negedge clk);
            rst = 1'b0;
            fl0 = 1'b0;
            #1;
            checks++;
            if (oc0 !== 2'd0 || ov0 !== 1'b0 || od0 !== 32'h0 || ir0 !== 1'b1) begin
                failures++;
                $display("FAIL rmid%0d: oc=%0d ov=%0b od=%h ir=%0b want 0 0 0 1",
                         m, oc0, ov0, od0, ir0);
            end
        end
    endtask

    task automatic test_soak();
        logic [127:0] m0 [4];
        logic [127:0] m1 [4];
        int           mn [4];
        logic         er, pu, po, sk, nop, wide;
        logic [127:0] nv;
        for (int k = 0; k < 4; k++) begin
            mn[k] = 0;
            m0[k] = '0;
            m1[k] = '0;
        end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                siv[k] = ($urandom_range(0, 2) != 0);
                sor[k] = ($urandom_range(0, 3) != 0);
                sfl[k] = ($urandom_range(0, 19) == 0);
                sid[k] = {$urandom, $urandom, $urandom, $urandom};
                if (k < 2) sid[k] = {127'b0, sid[k][0]};
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                sk   = (k == 1 || k == 3);
                nop  = (k == 0 || k == 3);
                wide = (k >= 2);
                nv   = wide ? 128'h13 : 128'h1;
                er   = sk ? (mn[k] != 2) : (mn[k] == 0 || sor[k]);
                checks++;
                if (sir[k] !== er) begin
                    failures++;
                    $display("FAIL soak%0d_ready c%0d: got %0b want %0b",
                             k, c, sir[k], er);
                end
                checks++;
                if (soc[k] !== 2'(mn[k]) || sov[k] !== (mn[k] != 0)) begin
                    failures++;
                    $display("FAIL soak%0d_occ c%0d: oc=%0d ov=%0b want %0d",
                             k, c, soc[k], sov[k], mn[k]);
                end
                checks++;
                if (mn[k] != 0 ? (sobs[k] !== m0[k]) : $isunknown(sobs[k])) begin
                    failures++;
                    $display("FAIL soak%0d_data c%0d: got %h want %h",
                             k, c, sobs[k], m0[k]);
                end
                pu = siv[k] && er;
                po = (mn[k] != 0) && sor[k];
                if (sfl[k]) begin
                    if (nop) begin
                        mn[k] = 1;
                        m0[k] = nv;
                    end else begin
                        mn[k] = 0;
                    end
                end else begin
                    if (po) begin
                        m0[k] = m1[k];
                        mn[k] = mn[k] - 1;
                    end
                    if (pu) begin
                        if (mn[k] == 0) m0[k] = sid[k];
                        else m1[k] = sid[k];
                        mn[k] = mn[k] + 1;
                    end
                end
            end
        end
        @(negedge clk);
        siv = '0;
        sfl = '0;
    endtask

    initial begin
        rst = 1'b1;
        fl0 = 0; iv0 = 0; or0 = 0; id0 = '0;
        fl1 = 0; iv1 = 0; or1 = 0; id1 = '0;
        fl2 = 0; iv2 = 0; or2 = 0; id2 = '0;
        sfl = '0; siv = '0; sor = '0; sid = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_comb_ready();
        test_flush_nop();
        test_flush_empty();
        test_reset_mid();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
